// File: rtl/idma_stream_sched_pkg.sv
// Shared types and constants for the per-stream iDMA transfer scheduler.
package idma_stream_sched_pkg;

  localparam int unsigned MaxStreams      = 16;
  localparam int unsigned DefaultDepth    = 2;
  localparam int unsigned DefaultMaxOutst = 4;

  typedef logic [3:0] stream_t;
  typedef logic [7:0] outst_cnt_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idma_stream_sched_if.sv
// Front-end, backend and completion signals of the stream scheduler.
// Optional macro IDMA_STREAM_SCHED_STARVE_CNT_EN adds the starve_cnt vector.
interface idma_stream_sched_if #(
  parameter int unsigned NumStreams     = 4,
  parameter int unsigned IdCounterWidth = 32,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned StreamWidth    = idma_stream_sched_pkg::idx_width(NumStreams)
);
  logic [DATA_W-1:0]                    req;
  logic [StreamWidth-1:0]               req_stream;
  logic                                 req_valid;
  logic                                 req_ready;
  logic [DATA_W-1:0]                    be_req;
  logic [StreamWidth-1:0]               be_stream;
  logic                                 be_valid;
  logic                                 be_ready;
  logic                                 cpl_valid;
  logic [StreamWidth-1:0]               cpl_stream;
  logic [NumStreams*IdCounterWidth-1:0] next_id;
  logic [NumStreams*IdCounterWidth-1:0] done_id;
  logic [NumStreams-1:0]                busy;
`ifdef IDMA_STREAM_SCHED_STARVE_CNT_EN
  logic [NumStreams*16-1:0]             starve_cnt;
`endif

  modport slave (
    input  req, req_stream, req_valid, be_ready, cpl_valid, cpl_stream,
    output req_ready, be_req, be_stream, be_valid, next_id, done_id, busy
`ifdef IDMA_STREAM_SCHED_STARVE_CNT_EN
    , starve_cnt
`endif
  );

  modport master (
    output req, req_stream, req_valid, be_ready, cpl_valid, cpl_stream,
    input  req_ready, be_req, be_stream, be_valid, next_id, done_id, busy
`ifdef IDMA_STREAM_SCHED_STARVE_CNT_EN
    , starve_cnt
`endif
  );
endinterface

// File: rtl/idma_stream_sched_fifo.sv
// Per-stream request buffer: registered storage, head visible the cycle after a push.
module idma_stream_sched_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned Depth  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;
  localparam ptr_t PtrLast = ptr_t'(Depth - 1);
  localparam cnt_t CntFull = cnt_t'(Depth);

  logic [DATA_W-1:0] mem [Depth];
  ptr_t rd_q, wr_q;
  cnt_t cnt_q;
  logic do_push, do_pop;

  function automatic ptr_t incr(input ptr_t p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CntFull);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= incr(wr_q);
      if (do_pop)  rd_q <= incr(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/idma_stream_sched.sv
// Per-stream transfer scheduler: buffers tagged requests, round-robins them onto one backend
// port with an outstanding limit, and tracks IDs. Macro IDMA_STREAM_SCHED_STARVE_CNT_EN adds starve counters.
module idma_stream_sched
  import idma_stream_sched_pkg::*;
#(
  parameter int unsigned NumStreams     = 4,
  parameter int unsigned FifoDepth      = DefaultDepth,
  parameter int unsigned MaxOutstanding = DefaultMaxOutst,
  parameter int unsigned IdCounterWidth = 32,
  parameter int unsigned DATA_W         = 64
) (
  input logic                clk,
  input logic                rst,
  idma_stream_sched_if.slave bus
);
  localparam int unsigned StreamWidth = idx_width(NumStreams);
  typedef logic [StreamWidth-1:0]    sw_t;
  typedef logic [IdCounterWidth-1:0] id_t;

  logic [NumStreams-1:0] full, empty, push, pop, eligible, cpl_sel, rot;
  logic [DATA_W-1:0]     head [NumStreams];
  sw_t  ptr, rr_grant, sel, lock_stream;
  logic rr_any, locked, be_valid, handshake;
  logic req_in_range, cpl_in_range;

  assign req_in_range  = int'(bus.req_stream) < int'(NumStreams);
  assign cpl_in_range  = int'(bus.cpl_stream) < int'(NumStreams);
  assign bus.req_ready = req_in_range ? !full[bus.req_stream] : 1'b1;

  // Rotate eligibility so the first set bit is the next stream at or after the pointer.
  always_comb begin
    rr_any   = 1'b0;
    rr_grant = '0;
    rot      = NumStreams'({eligible, eligible} >> ptr);
    for (int i = 0; i < int'(NumStreams); i++) begin
      if (!rr_any && rot[i]) begin
        rr_any   = 1'b1;
        rr_grant = sw_t'((int'(ptr) + i) % int'(NumStreams));
      end
    end
  end

  assign sel           = locked ? lock_stream : rr_grant;
  assign be_valid      = locked || rr_any;
  assign handshake     = be_valid && bus.be_ready;
  assign bus.be_valid  = be_valid;
  assign bus.be_stream = sel;
  assign bus.be_req    = head[sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked      <= 1'b0;
      lock_stream <= '0;
      ptr         <= '0;
    end else begin
      locked      <= be_valid && !bus.be_ready;
      lock_stream <= sel;
      if (handshake) ptr <= (int'(sel) == int'(NumStreams) - 1) ? '0 : sel + 1'b1;
    end
  end

  for (genvar s = 0; s < NumStreams; s++) begin : g_stream
    outst_cnt_t outst_q;
    id_t        next_q, done_q;
    logic       cpl_hit;

    assign push[s]     = bus.req_valid && bus.req_ready && req_in_range && (bus.req_stream == sw_t'(s));
    assign pop[s]      = handshake && (sel == sw_t'(s));
    assign cpl_sel[s]  = bus.cpl_valid && cpl_in_range && (bus.cpl_stream == sw_t'(s));
    assign cpl_hit     = cpl_sel[s] && (outst_q != '0);
    assign eligible[s] = !empty[s] && (outst_q < outst_cnt_t'(MaxOutstanding));

    idma_stream_sched_fifo #(.DATA_W(DATA_W), .Depth(FifoDepth)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[s]),
      .data  (bus.req),
      .pop   (pop[s]),
      .head  (head[s]),
      .full  (full[s]),
      .empty (empty[s])
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        outst_q <= '0;
        next_q  <= id_t'(1);
        done_q  <= '0;
      end else begin
        outst_q <= outst_q + outst_cnt_t'(pop[s]) - outst_cnt_t'(cpl_hit);
        if (push[s]) next_q <= next_q + 1'b1;
        if (cpl_hit) done_q <= done_q + 1'b1;
      end
    end

    assign bus.next_id[s*IdCounterWidth +: IdCounterWidth] = next_q;
    assign bus.done_id[s*IdCounterWidth +: IdCounterWidth] = done_q;
    assign bus.busy[s] = !empty[s] || (outst_q != '0);

    a_cpl_outstanding: assert property (@(posedge clk) disable iff (rst) cpl_sel[s] |-> (outst_q != '0));

`ifdef IDMA_STREAM_SCHED_STARVE_CNT_EN
    logic [15:0] starve_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_q <= '0;
      else if (eligible[s] && !pop[s] && (starve_q != '1)) starve_q <= starve_q + 1'b1;
    end
    assign bus.starve_cnt[s*16 +: 16] = starve_q;
`endif
  end
endmodule
